// File: rtl/alu_exec.sv
// Single-issue ALU with registered regfile writeback and an optional 16-step shift-add MAC.
// Define ALU_EXEC_MAC_EN to build op 8 (MAC); otherwise op 8 is treated as a NOP.
module alu_exec (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [3:0]  dest,
   input  logic [15:0] qa,
   input  logic [15:0] qb,
   input  logic [15:0] qc,
   output logic [15:0] d,
   output logic [3:0]  wn,
   output logic        we,
   output logic        busy,
   output logic        done,
   output logic        flag_z,
   output logic        flag_c
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WB   = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [15:0] d_q, d_d;
   logic [3:0]  wn_q, wn_d;
   logic        we_q, we_d, done_q, done_d, busy_q, busy_d;
   logic        fz_q, fz_d, fc_q, fc_d;
   logic [15:0] res;
   logic [16:0] sum;
   logic        cy;

`ifdef ALU_EXEC_MAC_EN
   localparam logic [1:0] MUL = 2'd1;
   logic [15:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d, acc_nxt;
   logic [3:0]  cnt_q, cnt_d, dest_q, dest_d;
`else
   logic unused_qc;
   assign unused_qc = ^qc;
`endif

   // Single-cycle ops are computed straight from the ports at the accepting edge,
   // so the registered result is immune to later operand changes.
   always_comb begin
      res = 16'h0000;
      cy  = 1'b0;
      sum = {1'b0, qa} + {1'b0, qb};
      case (op)
         4'd0: res = qa;
         4'd1: begin res = sum[15:0]; cy = sum[16]; end
         4'd2: begin res = qa - qb; cy = (qa < qb); end
         4'd3: res = qa & qb;
         4'd4: res = qa | qb;
         4'd5: res = qa ^ qb;
         4'd6: res = qa << qb[3:0];
         4'd7: res = qa >> qb[3:0];
         default: res = 16'h0000;
      endcase
   end

   always_comb begin
      state_d = state_q;
      d_d     = d_q;
      wn_d    = wn_q;
      we_d    = 1'b0;
      done_d  = 1'b0;
      fz_d    = fz_q;
      fc_d    = fc_q;
`ifdef ALU_EXEC_MAC_EN
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      dest_d   = dest_q;
      acc_nxt  = acc_q + (mplier_q[0] ? mcand_q : 16'h0000);
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               if (!op[3]) begin
                  state_d = WB;
                  d_d     = res;
                  wn_d    = dest;
                  we_d    = 1'b1;
                  done_d  = 1'b1;
                  fz_d    = (res == 16'h0000);
                  fc_d    = cy;
`ifdef ALU_EXEC_MAC_EN
               end else if (op == 4'd8) begin
                  state_d  = MUL;
                  acc_d    = qc;
                  mcand_d  = qa;
                  mplier_d = qb;
                  cnt_d    = 4'd0;
                  dest_d   = dest;
`endif
               end else begin
                  state_d = WB;
                  done_d  = 1'b1;
               end
            end
         end
`ifdef ALU_EXEC_MAC_EN
         MUL: begin
            acc_d    = acc_nxt;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
               state_d = WB;
               d_d     = acc_nxt;
               wn_d    = dest_q;
               we_d    = 1'b1;
               done_d  = 1'b1;
               fz_d    = (acc_nxt == 16'h0000);
               fc_d    = 1'b0;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         d_q     <= 16'h0000;
         wn_q    <= 4'h0;
         we_q    <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         fz_q    <= 1'b0;
         fc_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         d_q     <= d_d;
         wn_q    <= wn_d;
         we_q    <= we_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         fz_q    <= fz_d;
         fc_q    <= fc_d;
      end
   end

`ifdef ALU_EXEC_MAC_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         acc_q    <= 16'h0000;
         mcand_q  <= 16'h0000;
         mplier_q <= 16'h0000;
         cnt_q    <= 4'd0;
         dest_q   <= 4'h0;
      end else begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         dest_q   <= dest_d;
      end
   end
`endif

   assign d      = d_q;
   assign wn     = wn_q;
   assign we     = we_q;
   assign done   = done_q;
   assign busy   = busy_q;
   assign flag_z = fz_q;
   assign flag_c = fc_q;

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec with an expected-writeback scoreboard queue.
module tb_alu_exec;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  op = 4'd0, dest = 4'd0;
   logic [15:0] qa = 16'h0, qb = 16'h0, qc = 16'h0;
   logic [15:0] d;
   logic [3:0]  wn;
   logic        we, busy, done, flag_z, flag_c;

   typedef struct {
      logic [15:0] d;
      logic [3:0]  wn;
      logic        we;
      logic        z;
      logic        c;
   } exp_t;

   exp_t exp_q[$];
   exp_t last;
   int   n_cmp = 0;
   int   n_err = 0;

   alu_exec dut (
      .clock(clock), .reset(reset), .start(start), .op(op), .dest(dest),
      .qa(qa), .qb(qb), .qc(qc), .d(d), .wn(wn), .we(we), .busy(busy),
      .done(done), .flag_z(flag_z), .flag_c(flag_c)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference behaviour; also tracks the last written values for NOP expectations.
   function automatic exp_t mk(input logic [3:0] o, input logic [3:0] dst,
                               input logic [15:0] a, b, c);
      exp_t e;
      logic [16:0] s;
      logic [31:0] p;
      logic wr;
      e = last;
      e.we = 1'b0;
      wr = 1'b1;
      e.c = 1'b0;
      case (o)
         4'd0: e.d = a;
         4'd1: begin s = {1'b0, a} + {1'b0, b}; e.d = s[15:0]; e.c = s[16]; end
         4'd2: begin e.d = a - b; e.c = (a < b); end
         4'd3: e.d = a & b;
         4'd4: e.d = a | b;
         4'd5: e.d = a ^ b;
         4'd6: e.d = a << b[3:0];
         4'd7: e.d = a >> b[3:0];
`ifdef ALU_EXEC_MAC_EN
         4'd8: begin p = a * b + {16'h0, c}; e.d = p[15:0]; end
`endif
         default: wr = 1'b0;
      endcase
      if (wr) begin
         e.wn = dst;
         e.we = 1'b1;
         e.z  = (e.d == 16'h0000);
         last = e;
      end else begin
         e = last;
         e.we = 1'b0;
      end
      return e;
   endfunction

   task automatic cmp_pop(input string tag);
      exp_t e;
      if (exp_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd1, 32'd0);
         return;
      end
      e = exp_q.pop_front();
      chk({tag, "_we"}, we, e.we);
      chk({tag, "_d"}, d, e.d);
      chk({tag, "_wn"}, wn, e.wn);
      chk({tag, "_z"}, flag_z, e.z);
      chk({tag, "_c"}, flag_c, e.c);
   endtask

   // Called #1 after the accepting edge; waits for done, checks latency and busy span.
   task automatic wait_done(input string tag, input int exp_lat, input int pulse_at);
      int lat, bcnt;
      lat = 1;
      bcnt = 0;
      while (!done && lat < 40) begin
         if (busy) bcnt++;
         if (lat == pulse_at) begin op = 4'd1; start = 1'b1; end
         else start = 1'b0;
         @(posedge clock); #1;
         lat++;
      end
      start = 1'b0;
      if (busy) bcnt++;
      chk({tag, "_done"}, done, 1'b1);
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_busy_cyc"}, bcnt, exp_lat);
      cmp_pop(tag);
      @(posedge clock); #1;
      chk({tag, "_pulse"}, {busy, we, done}, 3'b000);
      @(posedge clock); #1;
      chk({tag, "_idle"}, {busy, done}, 2'b00);
   endtask

   // Operands are scrambled right after the accepting edge to prove they were latched.
   task automatic run_op(input string tag, input logic [3:0] o, dst,
                         input logic [15:0] a, b, c, input int exp_lat, input int pulse_at);
      @(negedge clock);
      op = o; dest = dst; qa = a; qb = b; qc = c; start = 1'b1;
      exp_q.push_back(mk(o, dst, a, b, c));
      @(posedge clock); #1;
      start = 1'b0;
      qa = a ^ 16'h3003; qb = b ^ 16'h5A5A; qc = c ^ 16'hFFFF;
      wait_done(tag, exp_lat, pulse_at);
   endtask

   initial begin
      last = '{d: 16'h0, wn: 4'h0, we: 1'b0, z: 1'b0, c: 1'b0};
      #12;
      chk("rst_outs", {d, wn, we, busy, done, flag_z, flag_c}, 32'h0);
      @(posedge clock); #1;
      reset = 1'b0;

      run_op("add", 4'd1, 4'd3, 16'hFFFF, 16'h0002, 16'h0, 1, 0);
      chk("add_lit", {d, wn, flag_c, flag_z}, {16'h0001, 4'd3, 1'b1, 1'b0});
      run_op("sub0", 4'd2, 4'd7, 16'h0005, 16'h0005, 16'h0, 1, 0);
      chk("sub0_lit", {d, flag_z, flag_c}, {16'h0000, 1'b1, 1'b0});
      run_op("subb", 4'd2, 4'd7, 16'h0001, 16'h0002, 16'h0, 1, 0);
      chk("subb_lit", {d, flag_c}, {16'hFFFF, 1'b1});
      run_op("pass", 4'd0, 4'd9, 16'h1001, 16'h0, 16'h0, 1, 0);
      chk("pass_lit", d, 16'h1001);
      run_op("and", 4'd3, 4'd1, 16'hF0F0, 16'h3C3C, 16'h0, 1, 0);
      run_op("or",  4'd4, 4'd2, 16'hF000, 16'h000F, 16'h0, 1, 0);
      run_op("xor", 4'd5, 4'd4, 16'hAAAA, 16'hAAAA, 16'h0, 1, 0);
      run_op("shr", 4'd7, 4'd5, 16'h8000, 16'h0013, 16'h0, 1, 0);
      run_op("shl0", 4'd6, 4'd6, 16'h1234, 16'h0010, 16'h0, 1, 0);
      chk("shl0_lit", d, 16'h1234);

`ifdef ALU_EXEC_MAC_EN
      run_op("mac", 4'd8, 4'd10, 16'h0012, 16'h0034, 16'h1001, 17, 6);
      chk("mac_lit", {d, wn, flag_c}, {16'h13A9, 4'd10, 1'b0});
      // Reset in the middle of the multiply: nothing may be written.
      @(negedge clock);
      op = 4'd8; dest = 4'd11; qa = 16'h00FF; qb = 16'h00FF; qc = 16'h0; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (8) begin @(posedge clock); #1; end
      chk("mrst_busy_pre", busy, 1'b1);
      reset = 1'b1;
      #1;
      chk("mrst_outs", {d, wn, we, busy, done, flag_z, flag_c}, 32'h0);
      @(posedge clock); #1;
      reset = 1'b0;
      last = '{d: 16'h0, wn: 4'h0, we: 1'b0, z: 1'b0, c: 1'b0};
      repeat (20) begin
         @(posedge clock); #1;
         chk("mrst_no_we", {we, busy}, 2'b00);
      end
      run_op("add2", 4'd1, 4'd12, 16'h8000, 16'h8000, 16'h0, 1, 0);
`else
      run_op("op8nop", 4'd8, 4'd10, 16'h0012, 16'h0034, 16'h1001, 1, 0);
      reset = 1'b1;
      #1;
      chk("rst2_outs", {d, wn, we, busy, done, flag_z, flag_c}, 32'h0);
      @(posedge clock); #1;
      reset = 1'b0;
      last = '{d: 16'h0, wn: 4'h0, we: 1'b0, z: 1'b0, c: 1'b0};
      run_op("add2", 4'd1, 4'd12, 16'h8000, 16'h8000, 16'h0, 1, 0);
`endif

      // start held high: a write every other cycle.
      @(negedge clock);
      op = 4'd6; dest = 4'd2; qa = 16'h0001; qb = 16'h000F; start = 1'b1;
      repeat (3) exp_q.push_back(mk(4'd6, 4'd2, 16'h0001, 16'h000F, 16'h0));
      @(posedge clock); #1;
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("b2b_we%0d", i), we, (i % 2 == 0));
         if (done) cmp_pop("b2b");
         if (i == 4) start = 1'b0;
         @(posedge clock); #1;
      end
      chk("b2b_sb_left", exp_q.size(), 0);
      run_op("nop15", 4'd15, 4'd13, 16'h5555, 16'h1, 16'h0, 1, 0);
      chk("nop15_lit", {d, wn, we}, {16'h8000, 4'd2, 1'b0});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 clock  input  1  single system clock; all state updates on its rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 start  input  1  request to execute one operation; sampled only in IDLE.
REQ-004 op  input  4  opcode: 0 PASS(qa), 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SHL, 7 SHR, 8 MAC; 9-15 NOP.
REQ-005 dest  input  4  destination register number to write back.
REQ-006 qa, qb, qc  input  16 each  operands from regfile read ports A/B/C.
REQ-007 d  output  16  writeback data to regfile.
REQ-008 wn  output  4  writeback register number.
REQ-009 we  output  1  writeback enable, one-cycle pulse.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 done  output  1  one-cycle pulse marking operation completion, including NOP.
REQ-012 flag_z, flag_c  output  1 each  zero and carry flags of the last written result.

Function
REQ-013 The block SHALL have three states, IDLE, MUL and WB; all outputs SHALL be registered.
REQ-014 In IDLE, start=1 at edge E0 SHALL latch op, dest, qa, qb and qc; later operand changes SHALL NOT affect the result.
REQ-015 Ops 0-7 SHALL move IDLE->WB at E0, with the result computed from the latched operands.
REQ-016 Op 8 SHALL move IDLE->MUL at E0, perform one shift-add step per cycle for 16 cycles (E1..E16), and move MUL->WB at E16.
REQ-017 In WB, we=1, done=1, d=result and wn=dest SHALL hold for exactly one cycle, then the state SHALL return to IDLE.
REQ-018 Write latency SHALL be 1 cycle after E0 for ops 0-7 and 17 cycles for MAC.
REQ-019 Ops 9-15 SHALL pass through WB with we=0 and done=1; d, wn and the flags SHALL be unchanged.
REQ-020 Arithmetic SHALL be modulo 2^16.
REQ-021 ADD SHALL set flag_c to the carry out of bit 15.
REQ-022 SUB (qa-qb) SHALL set flag_c to 1 on borrow (qa<qb).
REQ-023 All other ops SHALL set flag_c to 0.
REQ-024 flag_z SHALL be 1 when the written result is zero.
REQ-025 SHL and SHR SHALL shift qa by qb[3:0] positions with zero fill; a shift amount of 0 SHALL pass qa unchanged.
REQ-026 MAC SHALL produce the low 16 bits of qa*qb+qc.
REQ-027 start while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-028 start held high through WB SHALL be sampled again in the next IDLE cycle, giving back-to-back operations every 2 cycles.
REQ-029 Outside WB, we and done SHALL be 0; d and wn SHALL hold their last values.

Reset
REQ-030 reset=1 SHALL force IDLE asynchronously, including mid-MUL, and discard any in-flight operation without a write.
REQ-031 Reset values: d=16'h0000, wn=4'h0, we=0, busy=0, done=0, flag_z=0, flag_c=0, MUL iteration counter=0.
REQ-032 The first start SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-033 Macro ALU_EXEC_MAC_EN SHALL compile in op 8 (MAC).
REQ-034 When ALU_EXEC_MAC_EN is defined, op 8 SHALL behave as REQ-016/REQ-026 and MUL SHALL be reachable.
REQ-035 When ALU_EXEC_MAC_EN is undefined, op 8 SHALL behave as NOP (REQ-019), the MUL state and multiplier datapath SHALL be absent, and busy SHALL never exceed 1 cycle.

Verification
REQ-036 ADD qa=16'hFFFF, qb=16'h0002, dest=3 -> one cycle after start: we=1, wn=3, d=16'h0001, flag_c=1, flag_z=0.
REQ-037 SUB qa=16'h0005, qb=16'h0005, dest=7 -> d=16'h0000, flag_z=1, flag_c=0; then SUB qa=1, qb=2 -> d=16'hFFFF, flag_c=1.
REQ-038 MAC qa=16'h0012, qb=16'h0034, qc=16'h1001 (MAC_EN defined) -> busy for 17 cycles, we at cycle 17, d=16'h13A9; a start pulsed mid-operation is ignored.
REQ-039 Reset asserted at MUL iteration 8 -> busy=0, we stays 0, no write; next ADD completes normally.
REQ-040 start held high with op=SHL, qa=16'h0001, qb=16'h000F -> writes every 2 cycles, d=16'h8000; op=15 -> done=1, we=0, d unchanged.
REQ-041 Operands changed the cycle after start (PASS qa=16'h1001, then qa=16'h2002) -> written d=16'h1001.
